// File: rtl/rdback_collector.sv
// rdback_collector: captures DFI read bursts into a burst FIFO and streams
// each stored burst to the host as HOST_WIDTH words on a valid/ready port.
// Periodic-read responses are never stored; they only raise pr_rd_done.
//
// Host stream handshake: a word transfers on a rising clk edge where
// rdback_valid and rdback_ready are both 1. While rdback_valid=1 and
// rdback_ready=0, rdback_data and rdback_last hold their values and
// rdback_valid stays 1. rdback_valid never depends on rdback_ready.
module rdback_collector #(
  parameter int DQ_WIDTH   = 64,
  parameter int HOST_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dfi_rddata_valid,
  input  logic [4*DQ_WIDTH-1:0]           dfi_rddata,
  input  logic                            dfi_rddata_pr,
  output logic                            rdback_valid,
  output logic [HOST_WIDTH-1:0]           rdback_data,
  output logic                            rdback_last,
  input  logic                            rdback_ready,
  input  logic                            clr_overflow,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     burst_cnt,
  output logic                            pr_rd_done
);

  localparam int BURST_W = 4 * DQ_WIDTH;
  localparam int WORDS   = BURST_W / HOST_WIDTH;
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // IDLE waits for a stored burst, LOAD reads it out of the FIFO into the
  // shift register, SEND presents its words one at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BURST_W-1:0]   shift_q, shift_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          burst_cnt_q, burst_cnt_d;
  logic                 pr_done_q, pr_done_d;

  logic [BURST_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 push;
  logic                 drop;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // Capture side: classify the incoming burst against the registered count,
  // so a pop in the same cycle never makes room for it.
  always_comb begin
    push        = 1'b0;
    drop        = 1'b0;
    pr_done_d   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (dfi_rddata_valid) begin
      if (dfi_rddata_pr) begin
        pr_done_d = 1'b1;
      end else if (fifo_full) begin
        drop = 1'b1;
      end else begin
        push        = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        burst_cnt_d = burst_cnt_q + 16'd1;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear wins.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Serializer next-state: pops a burst in LOAD, or directly from SEND on
  // the accepted last word so consecutive bursts stream without a gap.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Only IDLE with a non-empty FIFO leads here, so a burst is present.
        pop      = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        shift_d  = mem_q[rd_ptr_q];
        idx_d    = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (rdback_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!fifo_empty) begin
              pop      = 1'b1;
              rd_ptr_d = rd_ptr_q + 1'b1;
              shift_d  = mem_q[rd_ptr_q];
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> HOST_WIDTH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      burst_cnt_q <= '0;
      pr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      burst_cnt_q <= burst_cnt_d;
      pr_done_q   <= pr_done_d;
    end
  end

  // Burst storage; contents are only meaningful between pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dfi_rddata;
    end
  end

  // The current word always sits in the low bits of the shift register.
  always_comb begin
    rdback_valid = (state_q == ST_SEND);
    rdback_data  = '0;
    rdback_last  = 1'b0;
    if (state_q == ST_SEND) begin
      rdback_data = shift_q[HOST_WIDTH-1:0];
      rdback_last = (idx_q == LAST_IDX);
    end
  end

  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign burst_cnt  = burst_cnt_q;
  assign pr_rd_done = pr_done_q;

endmodule

// File: tb/tb_rdback_collector.sv
// Bench for rdback_collector: table of single-burst vectors plus directed
// sequences for latency, periodic reads, backpressure, gapless streaming,
// overflow and asynchronous reset.
module tb_rdback_collector;

  logic         clk;
  logic         rst;
  logic         dfi_rddata_valid;
  logic [255:0] dfi_rddata;
  logic         dfi_rddata_pr;
  logic         rdback_valid;
  logic [31:0]  rdback_data;
  logic         rdback_last;
  logic         rdback_ready;
  logic         clr_overflow;
  logic         overflow;
  logic [3:0]   fifo_count;
  logic [15:0]  burst_cnt;
  logic         pr_rd_done;

  int n_pass;
  int n_total;
  int hs_cnt;
  int pr_cnt;

  logic [31:0] exp_q[$];
  logic [0:0]  exp_last_q[$];

  logic        prev_valid;
  logic        prev_ready;
  logic [31:0] prev_data;
  logic        prev_last;

  typedef struct {
    logic         pr;
    logic [255:0] data;
    logic [15:0]  exp_bc;
    int           exp_hs;
    int           exp_pr;
  } vec_t;

  vec_t vecs[5];

  rdback_collector dut (
    .clk              (clk),
    .rst              (rst),
    .dfi_rddata_valid (dfi_rddata_valid),
    .dfi_rddata       (dfi_rddata),
    .dfi_rddata_pr    (dfi_rddata_pr),
    .rdback_valid     (rdback_valid),
    .rdback_data      (rdback_data),
    .rdback_last      (rdback_last),
    .rdback_ready     (rdback_ready),
    .clr_overflow     (clr_overflow),
    .overflow         (overflow),
    .fifo_count       (fifo_count),
    .burst_cnt        (burst_cnt),
    .pr_rd_done       (pr_rd_done)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + 32'h01010101 * k;
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the burst is captured at the next edge.
  task automatic send_burst(input logic pr, input logic [255:0] d, input logic stored);
    dfi_rddata_valid = 1'b1;
    dfi_rddata_pr    = pr;
    dfi_rddata       = d;
    if (!pr && stored) begin
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back(d[k*32 +: 32]);
        exp_last_q.push_back(k == 7);
      end
    end
    sync();
    dfi_rddata_valid = 1'b0;
    dfi_rddata_pr    = 1'b0;
  endtask

  // Scoreboard and stability monitor on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", rdback_valid, 1'b1);
        chk("hold_data", rdback_data, prev_data);
        chk("hold_last", rdback_last, prev_last);
      end
      if (rdback_valid && rdback_ready) begin
        hs_cnt++;
        chk("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          chk("word_data", rdback_data, exp_q.pop_front());
          chk("word_last", rdback_last, exp_last_q.pop_front());
        end
      end
      if (pr_rd_done) pr_cnt++;
      prev_valid = rdback_valid;
      prev_ready = rdback_ready;
      prev_data  = rdback_data;
      prev_last  = rdback_last;
    end
  end

  initial begin
    int base_hs;
    int base_pr;
    int gaps;
    int started;
    logic found;
    logic [255:0] tmp;

    n_pass = 0; n_total = 0; hs_cnt = 0; pr_cnt = 0;
    rst = 1'b1;
    dfi_rddata_valid = 1'b0;
    dfi_rddata_pr = 1'b0;
    dfi_rddata = '0;
    rdback_ready = 1'b1;
    clr_overflow = 1'b0;

    vecs[0] = '{pr: 1'b0, data: mk(32'h01000010), exp_bc: 16'd2, exp_hs: 8, exp_pr: 0};
    vecs[1] = '{pr: 1'b1, data: mk(32'h55AA55AA), exp_bc: 16'd2, exp_hs: 0, exp_pr: 1};
    vecs[2] = '{pr: 1'b0, data: {256{1'b1}},      exp_bc: 16'd3, exp_hs: 8, exp_pr: 0};
    vecs[3] = '{pr: 1'b0, data: 256'd0,           exp_bc: 16'd4, exp_hs: 8, exp_pr: 0};
    vecs[4] = '{pr: 1'b1, data: {256{1'b1}},      exp_bc: 16'd4, exp_hs: 0, exp_pr: 1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", rdback_valid, 1'b0);
    chk("rst_data", rdback_data, 32'h0);
    chk("rst_last", rdback_last, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_burst_cnt", burst_cnt, 16'd0);
    chk("rst_pr_done", pr_rd_done, 1'b0);
    sync();

    // One burst: two-cycle latency, then 8 words
    base_hs = hs_cnt;
    send_burst(1'b0, {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                      32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, 1'b1);
    @(negedge clk);
    chk("t1_count_e0", fifo_count, 4'd1);
    chk("t1_valid_e0", rdback_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid_e1", rdback_valid, 1'b0);
    chk("t1_count_e1", fifo_count, 4'd1);
    @(negedge clk);
    chk("t1_valid_e2", rdback_valid, 1'b1);
    chk("t1_data_e2", rdback_data, 32'h0);
    chk("t1_count_e2", fifo_count, 4'd0);
    repeat (10) @(negedge clk);
    chk("t1_words", hs_cnt - base_hs, 8);
    chk("t1_count_end", fifo_count, 4'd0);
    chk("t1_burst_cnt", burst_cnt, 16'd1);
    chk("t1_valid_end", rdback_valid, 1'b0);
    sync();

    // Periodic read: pulse next cycle, nothing stored
    base_pr = pr_cnt;
    send_burst(1'b1, {8{32'hDEADBEEF}}, 1'b0);
    @(negedge clk);
    chk("t2_pr_pulse", pr_rd_done, 1'b1);
    chk("t2_count", fifo_count, 4'd0);
    @(negedge clk);
    chk("t2_pr_clear", pr_rd_done, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_valid", rdback_valid, 1'b0);
    chk("t2_burst_cnt", burst_cnt, 16'd1);
    chk("t2_pr_count", pr_cnt - base_pr, 1);
    sync();

    // Table of single bursts
    for (int v = 0; v < 5; v++) begin
      base_hs = hs_cnt;
      base_pr = pr_cnt;
      send_burst(vecs[v].pr, vecs[v].data, 1'b1);
      repeat (12) @(negedge clk);
      chk("vec_burst_cnt", burst_cnt, vecs[v].exp_bc);
      chk("vec_words", hs_cnt - base_hs, vecs[v].exp_hs);
      chk("vec_pr", pr_cnt - base_pr, vecs[v].exp_pr);
      chk("vec_count", fifo_count, 4'd0);
      chk("vec_overflow", overflow, 1'b0);
      sync();
    end

    // Backpressure: ready pattern 1,0,0 repeating
    base_hs = hs_cnt;
    send_burst(1'b0, mk(32'hB0000001), 1'b1);
    for (int i = 0; i < 40; i++) begin
      rdback_ready = (i % 3 == 0);
      sync();
    end
    rdback_ready = 1'b1;
    @(negedge clk);
    chk("bp_words", hs_cnt - base_hs, 8);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_burst_cnt", burst_cnt, 16'd5);
    sync();

    // Back-to-back bursts stream without gaps
    base_hs = hs_cnt;
    send_burst(1'b0, mk(32'h0A000000), 1'b1);
    send_burst(1'b0, mk(32'h0B000000), 1'b1);
    send_burst(1'b0, mk(32'h0C000000), 1'b1);
    gaps = 0;
    started = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdback_valid) started = 1;
      else if (started != 0 && (hs_cnt - base_hs) < 24) gaps++;
    end
    chk("b2b_words", hs_cnt - base_hs, 24);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_burst_cnt", burst_cnt, 16'd8);
    sync();

    // Overflow: the first burst is popped into the shift register even with
    // ready low, so 9 of the 10 bursts fit and only the 10th is dropped.
    rdback_ready = 1'b0;
    base_hs = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      send_burst(1'b0, mk(32'h10000000 * (i + 1)), i < 9);
    end
    @(negedge clk);
    chk("ovf_count", fifo_count, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_burst_cnt", burst_cnt, 16'd17);
    chk("ovf_valid_held", rdback_valid, 1'b1);
    sync();
    // Drop and clear in the same cycle: the flag stays set
    dfi_rddata_valid = 1'b1;
    dfi_rddata = mk(32'hEE000000);
    clr_overflow = 1'b1;
    sync();
    dfi_rddata_valid = 1'b0;
    clr_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_clr_drop", overflow, 1'b1);
    chk("ovf_clr_drop_count", fifo_count, 4'd8);
    chk("ovf_clr_drop_bc", burst_cnt, 16'd17);
    sync();
    rdback_ready = 1'b1;
    repeat (90) sync();
    @(negedge clk);
    chk("ovf_drain_words", hs_cnt - base_hs, 72);
    chk("ovf_drain_count", fifo_count, 4'd0);
    chk("ovf_drain_queue", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1'b1);
    sync();
    clr_overflow = 1'b1;
    sync();
    clr_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", overflow, 1'b0);
    sync();

    // Asynchronous reset while word 3 is on the bus
    tmp = mk(32'hC0C0C0C0);
    send_burst(1'b0, tmp, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rdback_valid && rdback_data == tmp[3*32 +: 32]) found = 1'b1;
    end
    chk("rst_mid_word3", found, 1'b1);
    #2;
    exp_q.delete();
    exp_last_q.delete();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", rdback_valid, 1'b0);
    chk("rst_mid_data", rdback_data, 32'h0);
    chk("rst_mid_last", rdback_last, 1'b0);
    chk("rst_mid_count", fifo_count, 4'd0);
    chk("rst_mid_bc", burst_cnt, 16'd0);
    chk("rst_mid_overflow", overflow, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    sync();
    base_hs = hs_cnt;
    send_burst(1'b0, mk(32'hF0000000), 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_first", rdback_data, 32'hF0000000);
    repeat (10) @(negedge clk);
    chk("post_rst_words", hs_cnt - base_hs, 8);
    chk("post_rst_bc", burst_cnt, 16'd1);
    chk("post_rst_count", fifo_count, 4'd0);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
